data_mem_ctrl: RTL and testbench

Parametrised data memory for the processor datapath. It is the next generation of the single-ported combinational data memory. It adds:
- a clocked write port with byte enables;
- a registered read port with a valid flag;
- a sequential zero-fill sweep that replaces the combinational reset clear, with a busy indication.

It sits between the ALU result/store-data path and the write-back mux, on the same clk/rst as the register file.

---
 rtl/mem_pkg.sv | 9 +
 rtl/byte_merge.sv | 15 +
 rtl/data_mem_ctrl.sv | 80 ++++++++
 tb/tb_data_mem_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for data_mem_ctrl (states, default sizes, byte count helper)
package mem_pkg;
   typedef enum logic {CLEAR, READY} state_t;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH = 32;
   function automatic int byte_cnt(input int w);
      return w / 8;
   endfunction
endpackage

// File: rtl/byte_merge.sv
// byte_merge: per-byte select between old_word and new_word; ports: old_word, new_word, byte_en in, merged out
module byte_merge
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0]           old_word,
   input  logic [DATA_W-1:0]           new_word,
   input  logic [byte_cnt(DATA_W)-1:0] byte_en,
   output logic [DATA_W-1:0]           merged
);
   for (genvar i = 0; i < byte_cnt(DATA_W); i++) begin : g_byte
      assign merged[8*i +: 8] = byte_en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data memory with byte-enable write, registered read, zero-fill sweep. Ports: clk, rst (async high), mem_read/rd_addr, mem_write/wr_addr/write_data/byte_en, clear in; read_data, read_valid, busy out. Define MEM_BYPASS_EN for write-first same-address reads (default read-first).
module data_mem_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        mem_read,
   input  logic                        mem_write,
   input  logic [ADDR_W-1:0]           rd_addr,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [DATA_W-1:0]           write_data,
   input  logic [byte_cnt(DATA_W)-1:0] byte_en,
   input  logic                        clear,
   output logic [DATA_W-1:0]           read_data,
   output logic                        read_valid,
   output logic                        busy
);
   localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   state_t state, next_state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic rd_en, wr_en, rd_in;
   logic [DATA_W-1:0] wr_word, rd_word;
   byte_merge #(.DATA_W(DATA_W)) u_merge (
      .old_word(mem[wr_addr]),
      .new_word(write_data),
      .byte_en (byte_en),
      .merged  (wr_word)
   );
   // busy comes straight from the state register, so no input reaches an output combinationally
   assign busy  = state == CLEAR;
   assign rd_in = {1'b0, rd_addr} < DEPTH_W;
   // a clear request in READY swallows any read/write of the same cycle
   always_comb begin
      next_state = state;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      if (state == CLEAR) begin
         next_state = ptr == LAST ? READY : CLEAR;
      end else if (clear) begin
         next_state = CLEAR;
      end else begin
         rd_en = mem_read;
         wr_en = mem_write && ({1'b0, wr_addr} < DEPTH_W);
      end
   end
`ifdef MEM_BYPASS_EN
   // same-address write forwards the merged word (it equals the old word merged under byte_en)
   logic same;
   assign same    = wr_en && rd_addr == wr_addr;
   assign rd_word = !rd_in ? '0 : same ? wr_word : mem[rd_addr];
`else
   assign rd_word = rd_in ? mem[rd_addr] : '0;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= CLEAR;
      else     state <= next_state;
   end
   // ptr parks at 0 outside the sweep so a new sweep always starts from word 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr        <= '0;
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         ptr        <= (state == CLEAR && ptr != LAST) ? ptr + 1'b1 : '0;
         read_valid <= rd_en;
         if (rd_en) read_data <= rd_word;
      end
   end
   always_ff @(posedge clk) begin
      if (state == CLEAR) mem[ptr] <= '0;
      else if (wr_en)     mem[wr_addr] <= wr_word;
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl (DEPTH=32 main instance, DEPTH=24 out-of-range instance)
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst, mem_read, mem_write, clear;
   logic [4:0]  rd_addr, wr_addr;
   logic [31:0] write_data, read_data;
   logic [3:0]  byte_en;
   logic        read_valid, busy;
   logic        b_rst, b_mem_read, b_mem_write, b_clear;
   logic [4:0]  b_rd_addr, b_wr_addr;
   logic [31:0] b_write_data, b_read_data;
   logic [3:0]  b_byte_en;
   logic        b_read_valid, b_busy;
   int n_chk = 0, n_fail = 0, cnt = 0;
   logic [31:0] model_mem [32];
   logic [31:0] exp_q [$];
   logic [31:0] last = '0;
   always #5 clk = ~clk;
   data_mem_ctrl #(.DATA_W(32), .DEPTH(32)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .rd_addr(rd_addr), .wr_addr(wr_addr), .write_data(write_data), .byte_en(byte_en),
      .clear(clear), .read_data(read_data), .read_valid(read_valid), .busy(busy)
   );
   data_mem_ctrl #(.DATA_W(32), .DEPTH(24), .ADDR_W(5)) dut_b (
      .clk(clk), .rst(b_rst), .mem_read(b_mem_read), .mem_write(b_mem_write),
      .rd_addr(b_rd_addr), .wr_addr(b_wr_addr), .write_data(b_write_data), .byte_en(b_byte_en),
      .clear(b_clear), .read_data(b_read_data), .read_valid(b_read_valid), .busy(b_busy)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
      return r;
   endfunction
   task automatic zero_model();
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
   endtask
   // one clock of stimulus; the model predicts, the scoreboard compares after the edge
   task automatic step(input bit rd, input logic [4:0] ra, input bit wr, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be, input bit clr);
      bit exp_v;
      logic [31:0] e;
      exp_v = 1'b0;
      mem_read = rd; rd_addr = ra; mem_write = wr; wr_addr = wa;
      write_data = wd; byte_en = be; clear = clr;
      if (cnt > 0) cnt--;
      else if (clr) begin
         cnt = 32;
         zero_model();
      end else begin
         if (rd) begin
            e = model_mem[ra];
`ifdef MEM_BYPASS_EN
            if (wr && wa == ra) e = merge(e, wd, be);
`endif
            exp_q.push_back(e);
            exp_v = 1'b1;
         end
         if (wr) model_mem[wa] = merge(model_mem[wa], wd, be);
      end
      @(posedge clk); #1;
      chk("busy", {31'b0, busy}, {31'b0, cnt != 0});
      chk("read_valid", {31'b0, read_valid}, {31'b0, exp_v});
      if (exp_v) begin
         if (exp_q.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
         else last = exp_q.pop_front();
      end
      chk("read_data", read_data, last);
      mem_read = 1'b0; mem_write = 1'b0; clear = 1'b0;
   endtask
   task automatic idle();
      step(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
   endtask
   task automatic do_rst();
      rst = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; clear = 1'b0;
      #1;
      chk("rst_read_valid", {31'b0, read_valid}, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("rst_hold_busy", {31'b0, busy}, 32'd1);
      chk("rst_hold_valid", {31'b0, read_valid}, 32'd0);
      rst = 1'b0;
      cnt = 32;
      zero_model();
      exp_q.delete();
      last = '0;
   endtask
   initial begin
      int n;
      rst = 1'b1; mem_read = 0; mem_write = 0; clear = 0;
      rd_addr = 0; wr_addr = 0; write_data = 0; byte_en = 0;
      b_rst = 1'b1; b_mem_read = 0; b_mem_write = 0; b_clear = 0;
      b_rd_addr = 0; b_wr_addr = 0; b_write_data = 0; b_byte_en = 0;
      #1;
      do_rst();
      while (cnt > 0) idle();
      for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
      step(1'b0, 5'd0, 1'b1, 5'd5, 32'hAABBCCDD, 4'b1111, 1'b0);
      step(1'b0, 5'd0, 1'b1, 5'd5, 32'h11223344, 4'b0101, 1'b0);
      step(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
      chk("byte_en_word", read_data, 32'hAA22CC44);
      step(1'b0, 5'd0, 1'b1, 5'd7, 32'd0, 4'b1111, 1'b0);
      step(1'b1, 5'd7, 1'b1, 5'd7, 32'hDEADBEEF, 4'b1111, 1'b0);
`ifdef MEM_BYPASS_EN
      chk("same_addr_rw", read_data, 32'hDEADBEEF);
`else
      chk("same_addr_rw", read_data, 32'h00000000);
`endif
      step(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
      chk("same_addr_after", read_data, 32'hDEADBEEF);
      step(1'b1, 5'd5, 1'b1, 5'd9, 32'h12345678, 4'b1111, 1'b0);
      step(1'b1, 5'd9, 1'b1, 5'd5, 32'h99000000, 4'b1000, 1'b0);
      step(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 49) == 0);
      while (cnt > 0) idle();
      step(1'b0, 5'd0, 1'b1, 5'd3, 32'h5, 4'b1111, 1'b0);
      step(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1);
      step(1'b1, 5'd3, 1'b1, 5'd3, 32'h9, 4'b1111, 1'b0);
      while (cnt > 0) idle();
      step(1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
      chk("clear_addr3", read_data, 32'd0);
      step(1'b0, 5'd0, 1'b1, 5'd5, 32'hCAFEF00D, 4'b1111, 1'b0);
      step(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
      do_rst();
      while (cnt > 0) idle();
      step(1'b0, 5'd0, 1'b1, 5'd5, 32'hCAFEF00D, 4'b1111, 1'b0);
      step(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0);
      step(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b1);
      repeat (10) idle();
      do_rst();
      n = 0;
      while (cnt > 0) begin
         idle();
         n++;
      end
      chk("resweep_len", n, 32);
      #1;
      b_rst = 1'b0;
      n = 0;
      while (b_busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b_sweep_len", n, 24);
      b_mem_write = 1'b1; b_wr_addr = 5'd30; b_write_data = 32'hFFFFFFFF; b_byte_en = 4'b1111;
      @(posedge clk); #1;
      b_mem_write = 1'b0; b_mem_read = 1'b1; b_rd_addr = 5'd30;
      @(posedge clk); #1;
      chk("b_oor_valid", {31'b0, b_read_valid}, 32'd1);
      chk("b_oor_data", b_read_data, 32'd0);
      b_rd_addr = 5'd24;
      @(posedge clk); #1;
      chk("b_oor24_data", b_read_data, 32'd0);
      for (int i = 0; i < 24; i++) begin
         b_rd_addr = 5'(i);
         @(posedge clk); #1;
         chk("b_unchanged", b_read_data, 32'd0);
      end
      b_mem_read = 1'b0; b_mem_write = 1'b1; b_wr_addr = 5'd23; b_write_data = 32'h55AA55AA;
      @(posedge clk); #1;
      b_mem_write = 1'b0; b_mem_read = 1'b1; b_rd_addr = 5'd23;
      @(posedge clk); #1;
      chk("b_last_word", b_read_data, 32'h55AA55AA);
      b_mem_read = 1'b0;
      @(posedge clk); #1;
      chk("b_idle_valid", {31'b0, b_read_valid}, 32'd0);
      chk("b_idle_hold", b_read_data, 32'h55AA55AA);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
